uart_clk_gen: RTL and testbench



---
 rtl/uart_clk_gen_pkg.sv | 72 +++++++
 rtl/uart_clk_gen_channel.sv | 78 +++++++
 rtl/uart_clk_gen.sv | 70 +++++++
 tb/tb_uart_clk_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_clk_gen_pkg.sv
// Shared definitions for the UART baud clock generator: select encodings,
// half-period arithmetic and the per-channel state encoding.
package uart_clk_gen_pkg;

  localparam logic [2:0] SEL_9600   = 3'b000;
  localparam logic [2:0] SEL_19200  = 3'b001;
  localparam logic [2:0] SEL_38400  = 3'b010;
  localparam logic [2:0] SEL_57600  = 3'b011;
  localparam logic [2:0] SEL_115200 = 3'b100;
  localparam logic [2:0] SEL_230400 = 3'b101;
  localparam logic [2:0] SEL_460800 = 3'b110;
  localparam logic [2:0] SEL_921600 = 3'b111;

  localparam int HALF_W  = 16;
  localparam int NUM_SEL = 8;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  function automatic longint baud_of(input logic [2:0] sel);
    case (sel)
      SEL_9600:   return 64'd9600;
      SEL_19200:  return 64'd19200;
      SEL_38400:  return 64'd38400;
      SEL_57600:  return 64'd57600;
      SEL_115200: return 64'd115200;
      SEL_230400: return 64'd230400;
      SEL_460800: return 64'd460800;
      default:    return 64'd921600;
    endcase
  endfunction

  // Rounded half bit period in system clocks.
  function automatic longint half_period(input longint clk_freq, input longint baud);
    return (clk_freq + baud) / (2 * baud);
  endfunction

  function automatic longint half_for_sel(input longint clk_freq, input logic [2:0] sel);
    return half_period(clk_freq, baud_of(sel));
  endfunction

  function automatic longint min_half(input longint clk_freq);
    longint m;
    m = half_for_sel(clk_freq, 3'd0);
    for (int i = 1; i < NUM_SEL; i++) begin
      if (half_for_sel(clk_freq, 3'(i)) < m) m = half_for_sel(clk_freq, 3'(i));
    end
    return m;
  endfunction

  function automatic longint max_half(input longint clk_freq);
    longint m;
    m = half_for_sel(clk_freq, 3'd0);
    for (int i = 1; i < NUM_SEL; i++) begin
      if (half_for_sel(clk_freq, 3'(i)) > m) m = half_for_sel(clk_freq, 3'(i));
    end
    return m;
  endfunction

  // All eight half periods packed into one constant, entry i at [i*HALF_W +: HALF_W].
  function automatic logic [NUM_SEL*HALF_W-1:0] half_table(input longint clk_freq);
    logic [NUM_SEL*HALF_W-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      t[i*HALF_W +: HALF_W] = HALF_W'(half_for_sel(clk_freq, 3'(i)));
    end
    return t;
  endfunction

endpackage

// File: rtl/uart_clk_gen_channel.sv
// One baud clock channel: select latch, half-period divider and IDLE/RUN FSM.
// clk_uart idles high and falls on the same edge that accepts the run request.
module uart_clk_channel
  import uart_clk_gen_pkg::*;
#(
  parameter logic [2:0] DEFAULT_SEL = SEL_115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        baud_sel,
  input  logic [HALF_W-1:0] half_new,
  input  logic [HALF_W-1:0] half_cur,
  output logic [2:0]        sel_q,
  output logic              clk_uart,
  output logic              active
);

  ch_state_e         state_q, state_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              clk_q, clk_d;
  logic [2:0]        sel_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b1;
      sel_q   <= DEFAULT_SEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      sel_q   <= sel_d;
    end
  end

  // half_new is H of the live select (used at start); half_cur is H of the latched one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    sel_d   = sel_q;
    case (state_q)
      CH_IDLE: begin
        sel_d = baud_sel;
        cnt_d = '0;
        clk_d = 1'b1;
        if (enable) begin
          state_d = CH_RUN;
          cnt_d   = half_new - HALF_W'(1);
          clk_d   = 1'b0;
        end
      end
      CH_RUN: begin
        if (!enable) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b1;
        end else if (cnt_q == '0) begin
          clk_d = ~clk_q;
          cnt_d = half_cur - HALF_W'(1);
        end else begin
          cnt_d = cnt_q - HALF_W'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        clk_d   = 1'b1;
      end
    endcase
  end

  assign clk_uart = clk_q;
  assign active   = (state_q == CH_RUN);

endmodule

// File: rtl/uart_clk_gen.sv
// Dual-channel UART baud clock generator: a shared select-to-half-period lookup
// feeding independent TX and RX channels.
module uart_clk_gen
  import uart_clk_gen_pkg::*;
#(
  parameter int         CLK_FREQ    = 100_000_000,
  parameter logic [2:0] DEFAULT_SEL = SEL_115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_sel,
  input  logic       uart_enable_tx,
  input  logic       uart_enable_rx,
  output logic       clk_uart_tx,
  output logic       clk_uart_rx,
  output logic       active_tx,
  output logic       active_rx
);

  localparam longint H_MIN = min_half(longint'(CLK_FREQ));
  localparam longint H_MAX = max_half(longint'(CLK_FREQ));
  localparam logic [NUM_SEL*HALF_W-1:0] H_TABLE = half_table(longint'(CLK_FREQ));

  if (H_MIN < 2) begin : g_half_too_small
    $error("uart_clk_gen: CLK_FREQ too low, a half period is below 2 clocks");
  end
  if (H_MAX > ((longint'(1) << HALF_W) - 1)) begin : g_half_too_large
    $error("uart_clk_gen: CLK_FREQ too high, a half period overflows the counter");
  end

  function automatic logic [HALF_W-1:0] h_lookup(input logic [2:0] sel);
    return H_TABLE[int'(sel)*HALF_W +: HALF_W];
  endfunction

  logic [2:0]        sel_tx, sel_rx;
  logic [HALF_W-1:0] half_live, half_tx, half_rx;

  assign half_live = h_lookup(baud_sel);
  assign half_tx   = h_lookup(sel_tx);
  assign half_rx   = h_lookup(sel_rx);

  uart_clk_channel #(
    .DEFAULT_SEL (DEFAULT_SEL)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .enable   (uart_enable_tx),
    .baud_sel (baud_sel),
    .half_new (half_live),
    .half_cur (half_tx),
    .sel_q    (sel_tx),
    .clk_uart (clk_uart_tx),
    .active   (active_tx)
  );

  uart_clk_channel #(
    .DEFAULT_SEL (DEFAULT_SEL)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .enable   (uart_enable_rx),
    .baud_sel (baud_sel),
    .half_new (half_live),
    .half_cur (half_rx),
    .sel_q    (sel_rx),
    .clk_uart (clk_uart_rx),
    .active   (active_rx)
  );

endmodule

// File: tb/tb_uart_clk_gen.sv
// Self-checking bench for uart_clk_gen: a phase-count model checked every cycle,
// plus directed edge-timing measurements against hand-computed values.
module tb_uart_clk_gen;

  localparam int CLK_FREQ = 100_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] baud_sel = 3'b100;
  logic       uart_enable_tx = 1'b0;
  logic       uart_enable_rx = 1'b0;
  logic       clk_uart_tx, clk_uart_rx, active_tx, active_rx;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  uart_clk_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .DEFAULT_SEL (3'b100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_sel       (baud_sel),
    .uart_enable_tx (uart_enable_tx),
    .uart_enable_rx (uart_enable_rx),
    .clk_uart_tx    (clk_uart_tx),
    .clk_uart_rx    (clk_uart_rx),
    .active_tx      (active_tx),
    .active_rx      (active_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hcalc(input logic [2:0] sel);
    int baud;
    case (sel)
      3'd0: baud = 9600;
      3'd1: baud = 19200;
      3'd2: baud = 38400;
      3'd3: baud = 57600;
      3'd4: baud = 115200;
      3'd5: baud = 230400;
      3'd6: baud = 460800;
      default: baud = 921600;
    endcase
    return (CLK_FREQ + baud) / (2 * baud);
  endfunction

  // Model: per channel, whether running, its half period, and clocks since the fall.
  bit   m_run [2] = '{1'b0, 1'b0};
  int   m_h   [2] = '{0, 0};
  int   m_p   [2] = '{0, 0};
  logic [1:0] en_v;
  assign en_v = {uart_enable_rx, uart_enable_tx};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_run[c] <= 1'b0;
        m_h[c]   <= 0;
        m_p[c]   <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!m_run[c]) begin
          if (en_v[c]) begin
            m_run[c] <= 1'b1;
            m_h[c]   <= hcalc(baud_sel);
            m_p[c]   <= 0;
          end
        end else if (!en_v[c]) begin
          m_run[c] <= 1'b0;
        end else begin
          m_p[c] <= m_p[c] + 1;
        end
      end
    end
  end

  function automatic int exp_clk(input int c);
    if (!m_run[c]) return 1;
    return ((m_p[c] / m_h[c]) % 2 == 1) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_clk_uart_tx", int'(clk_uart_tx), exp_clk(0));
      chk("model_clk_uart_rx", int'(clk_uart_rx), exp_clk(1));
      chk("model_active_tx", int'(active_tx), int'(m_run[0]));
      chk("model_active_rx", int'(active_rx), int'(m_run[1]));
    end
  end

  // Counts falling clk edges until the channel output reaches lvl.
  task automatic wait_level(input int ch, input logic lvl, input int limit, output int n);
    logic v;
    for (n = 1; n <= limit; n++) begin
      @(negedge clk);
      v = (ch == 0) ? clk_uart_tx : clk_uart_rx;
      if (v === lvl) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_timeout: ch%0d never reached %0d within %0d cycles", ch, lvl, limit);
  endtask

  initial begin
    int n, tot;

    chk("hcalc_9600", hcalc(3'd0), 5208);
    chk("hcalc_115200", hcalc(3'd4), 434);
    chk("hcalc_921600", hcalc(3'd7), 54);

    repeat (3) @(negedge clk);
    chk("rst_clk_tx", int'(clk_uart_tx), 1);
    chk("rst_clk_rx", int'(clk_uart_rx), 1);
    chk("rst_active_tx", int'(active_tx), 0);
    chk("rst_active_rx", int'(active_rx), 0);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    repeat (10000) @(negedge clk);
    chk("idle_clk_tx", int'(clk_uart_tx), 1);
    chk("idle_active_rx", int'(active_rx), 0);

    // TX at 115200
    #1 uart_enable_tx = 1'b1;
    wait_level(0, 1'b0, 10, n);
    chk("tx_first_fall", n, 1);
    chk("tx_active", int'(active_tx), 1);
    wait_level(0, 1'b1, 2000, n);
    chk("tx_low_phase", n, 434);
    wait_level(0, 1'b0, 2000, n);
    chk("tx_high_phase", n, 434);

    // select change while running must not alter the rate
    #1 baud_sel = 3'b111;
    wait_level(0, 1'b1, 2000, n);
    tot = n;
    wait_level(0, 1'b0, 2000, n);
    tot += n;
    chk("tx_period_kept", tot, 868);

    repeat (5) @(negedge clk);
    #1 uart_enable_tx = 1'b0;
    @(negedge clk);
    chk("tx_stop_clk", int'(clk_uart_tx), 1);
    chk("tx_stop_active", int'(active_tx), 0);

    repeat (3) @(negedge clk);
    #1 uart_enable_tx = 1'b1;
    wait_level(0, 1'b0, 10, n);
    chk("tx_fast_first_fall", n, 1);
    wait_level(0, 1'b1, 200, n);
    tot = n;
    wait_level(0, 1'b0, 200, n);
    tot += n;
    chk("tx_fast_period", tot, 108);

    // one-clock enable gap while low: one high clock, then a fresh fall
    #1 uart_enable_tx = 1'b0;
    @(negedge clk);
    chk("gap_high", int'(clk_uart_tx), 1);
    #1 uart_enable_tx = 1'b1;
    @(negedge clk);
    chk("gap_fall", int'(clk_uart_tx), 0);
    wait_level(0, 1'b1, 200, n);
    chk("gap_low_phase", n, 54);
    #1 begin
      uart_enable_tx = 1'b0;
      baud_sel = 3'b000;
    end

    // RX at 9600, TX joins later at 115200
    @(negedge clk);
    #1 uart_enable_rx = 1'b1;
    wait_level(1, 1'b0, 10, n);
    chk("rx_first_fall", n, 1);
    #1 begin
      baud_sel = 3'b100;
      uart_enable_tx = 1'b1;
    end
    wait_level(1, 1'b1, 20000, n);
    chk("rx_low_phase", n, 5208);
    tot = n;
    wait_level(1, 1'b0, 20000, n);
    tot += n;
    wait_level(1, 1'b1, 20000, n);
    tot += n;
    chk("rx_second_rise", tot, 15624);
    chk("tx_active_concurrent", int'(active_tx), 1);

    // asynchronous reset mid-run
    repeat (37) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_clk_tx", int'(clk_uart_tx), 1);
    chk("arst_clk_rx", int'(clk_uart_rx), 1);
    chk("arst_active_tx", int'(active_tx), 0);
    chk("arst_active_rx", int'(active_rx), 0);
    uart_enable_tx = 1'b0;
    uart_enable_rx = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
